// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy-state type for the FIFO-to-AXI-Stream drain.
// Holds the default word width, default packet length and the EMPTY/ONE/TWO enum.
package fifo_pkg;

    localparam int F_WIDTH_DEF = 8;
    localparam int PKT_LEN_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry (main + skid) output buffer between a show-ahead FIFO and an AXI-Stream sink.
// Ports: clk, rst (async, active-low), in_data/in_push (word accepted this edge),
//        out_ready (sink ready), out_data/out_valid (stream head), full (both entries used).
module axis_skid_reg
    import fifo_pkg::*;
#(
    parameter int W = F_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_push,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         full
);

    occ_t         state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         valid_q;
    logic         full_q;
    logic         xfer;

    assign xfer = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_push) begin
                        main_q  <= in_data;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (in_push && xfer) begin
                        main_q <= in_data;
                    end else if (in_push) begin
                        // Sink stalled: park the new word behind the head.
                        skid_q <= in_data;
                        full_q <= 1'b1;
                        state  <= TWO;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    // No pop can arrive here; the caller gates it with full.
                    if (xfer) begin
                        main_q <= skid_q;
                        full_q <= 1'b0;
                        state  <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    full_q  <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

    assign out_data  = main_q;
    assign out_valid = valid_q;
    assign full      = full_q;

endmodule

// File: rtl/fifo_axis_drain.sv
// Drains a show-ahead FIFO onto an AXI-Stream master port with optional tlast framing.
// Ports: clk, rst (async, active-low), fifo_dout/fifo_empty/fifo_deq (FIFO side),
//        m_tdata/m_tvalid/m_tready/m_tlast (stream side).
// Build option: define FIFO_DRAIN_TLAST_EN to enable the PKT_LEN beat counter and m_tlast.
module fifo_axis_drain
    import fifo_pkg::*;
#(
    parameter int F_WIDTH = F_WIDTH_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [F_WIDTH-1:0] fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_deq,
    output logic [F_WIDTH-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast
);

    logic full;
    logic pop;

    // Reset holds the request low so nothing is lost from the FIFO.
    assign fifo_deq = rst & ~fifo_empty & ~full;
    assign pop      = fifo_deq & ~fifo_empty;

    axis_skid_reg #(
        .W(F_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (fifo_dout),
        .in_push  (pop),
        .out_ready(m_tready),
        .out_data (m_tdata),
        .out_valid(m_tvalid),
        .full     (full)
    );

`ifdef FIFO_DRAIN_TLAST_EN
    localparam int CW = $clog2(PKT_LEN);
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    logic [CW-1:0] beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (m_tvalid && m_tready) begin
            beat <= (beat == LAST) ? '0 : beat + CW'(1);
        end
    end

    assign m_tlast = m_tvalid & (beat == LAST);
`else
    logic unused_cfg;

    assign unused_cfg = (PKT_LEN > 0);
    assign m_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Directed + randomized bench for fifo_axis_drain with a queue-style FIFO model
// and an in-order scoreboard on the stream side.
module tb_fifo_axis_drain;

    localparam int W   = 8;
    localparam int PKT = 4;
`ifdef FIFO_DRAIN_TLAST_EN
    localparam bit TL_EN = 1'b1;
`else
    localparam bit TL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_deq;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;

    logic [W-1:0] mem [0:2047];
    int           rd = 0;
    int           wr = 0;
    logic         gate = 1'b0;

    int           ncmp = 0;
    int           nerr = 0;
    int           sc_idx = 0;
    int           beat = 0;
    int           ntlast = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    assign fifo_dout  = mem[rd[10:0]];
    assign fifo_empty = (rd == wr) || gate;

    fifo_axis_drain #(
        .F_WIDTH(W),
        .PKT_LEN(PKT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_deq  (fifo_deq),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast)
    );

    always @(posedge clk) begin
        if (fifo_deq && !fifo_empty) rd <= rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wr[10:0]] = d;
        wr = wr + 1;
    endtask

    // Stream-side scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                chk("stall_data", {24'd0, m_tdata}, {24'd0, prev_data});
                chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
            end
            if (!m_tvalid) chk("tlast_idle", {31'd0, m_tlast}, 32'd0);
            if (m_tvalid && m_tready) begin
                chk("order", {24'd0, m_tdata}, {24'd0, mem[sc_idx[10:0]]});
                chk("tlast", {31'd0, m_tlast}, {31'd0, TL_EN && (beat == PKT - 1)});
                if (m_tlast) ntlast++;
                sc_idx++;
                beat = (beat + 1) % PKT;
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int base;
        int t0;
        rst      = 1'b0;
        m_tready = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        tick();
        tick();
        chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
        chk("rst_deq", {31'd0, fifo_deq}, 32'd0);
        rst = 1'b1;

        // Streaming at full rate.
        tick();
        chk("s1_d0", {24'd0, m_tdata}, 32'h11);
        chk("s1_v0", {31'd0, m_tvalid}, 32'd1);
        tick();
        chk("s1_d1", {24'd0, m_tdata}, 32'h22);
        tick();
        chk("s1_d2", {24'd0, m_tdata}, 32'h33);
        tick();
        chk("s1_idle", {31'd0, m_tvalid}, 32'd0);

        // Backpressure: two pops fill main+skid, then the FIFO is left alone.
        m_tready = 1'b0;
        base = rd;
        push(8'h44);
        push(8'h55);
        push(8'h66);
        push(8'h77);
        tick();
        chk("s2_d0", {24'd0, m_tdata}, 32'h44);
        chk("s2_deq1", {31'd0, fifo_deq}, 32'd1);
        chk("s2_tlast", {31'd0, m_tlast}, {31'd0, TL_EN});
        tick();
        chk("s2_deq2", {31'd0, fifo_deq}, 32'd0);
        tick();
        tick();
        tick();
        chk("s2_pops", rd - base, 32'd2);
        chk("s2_hold", {24'd0, m_tdata}, 32'h44);
        chk("s2_deq5", {31'd0, fifo_deq}, 32'd0);
        m_tready = 1'b1;
        tick();
        chk("s2_d1", {24'd0, m_tdata}, 32'h55);
        chk("s2_deq_rel", {31'd0, fifo_deq}, 32'd1);
        tick();
        chk("s2_d2", {24'd0, m_tdata}, 32'h66);
        tick();
        chk("s2_d3", {24'd0, m_tdata}, 32'h77);
        tick();
        chk("s2_idle", {31'd0, m_tvalid}, 32'd0);

        // Reset in TWO mid-packet.
        m_tready = 1'b0;
        push(8'h81);
        push(8'h82);
        push(8'h83);
        tick();
        tick();
        chk("s3_full_deq", {31'd0, fifo_deq}, 32'd0);
        chk("s3_head", {24'd0, m_tdata}, 32'h81);
        rst = 1'b0;
        #1;
        chk("s3_rst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("s3_rst_deq", {31'd0, fifo_deq}, 32'd0);
        chk("s3_rst_tdata", {24'd0, m_tdata}, 32'd0);
        sc_idx = rd;
        beat   = 0;
        tick();
        rst      = 1'b1;
        m_tready = 1'b1;
        t0       = ntlast;
        for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
        tick();
        chk("s3_first", {24'd0, m_tdata}, 32'h83);
        chk("s3_first_tlast", {31'd0, m_tlast}, 32'd0);
        for (int i = 0; i < 200 && !(sc_idx == wr && !m_tvalid); i++) tick();
        chk("s3_drain", sc_idx, wr);
        chk("s3_tlast_cnt", ntlast - t0, TL_EN ? 32'd2 : 32'd0);

        // Random ready and FIFO-empty toggling over 1000 words.
        for (int i = 0; i < 1000; i++) push(8'($urandom));
        for (int i = 0; i < 20000 && sc_idx != wr; i++) begin
            m_tready = 1'($urandom);
            gate     = ($urandom_range(0, 3) == 0);
            tick();
        end
        m_tready = 1'b1;
        gate     = 1'b0;
        for (int i = 0; i < 20 && !(sc_idx == wr && !m_tvalid); i++) tick();
        chk("rnd_count", sc_idx, wr);
        chk("rnd_popped", rd, wr);
        chk("rnd_idle", {31'd0, m_tvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
